demux_rr_scheduler: RTL and testbench

Round-robin scheduler for the 1:8 demultiplexer. It shares a single 1-bit input stream among eight destination requesters. Each grant is a fixed-length burst. The block drives the demux `sel` and gated input bit, tracks beats, and rotates fairness priority after each burst.

---
 rtl/demux_rr_if.sv | 22 ++
 rtl/demux_rr_scheduler.sv | 132 +++++++++++++
 tb/tb_demux_rr_scheduler.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/demux_rr_if.sv
// Bundle between the eight requesters/source and the 1:8 demux round-robin scheduler.
interface demux_rr_if;
  logic [7:0] dst_req;
  logic       in_valid;
  logic       in_data;
  logic       in_ready;
  logic       demux_i;
  logic [2:0] sel;
  logic [7:0] grant;
  logic       burst_done;
  logic       burst_abort;

  modport master (
    output dst_req, in_valid, in_data,
    input  in_ready, demux_i, sel, grant, burst_done, burst_abort
  );

  modport slave (
    input  dst_req, in_valid, in_data,
    output in_ready, demux_i, sel, grant, burst_done, burst_abort
  );
endinterface

// File: rtl/demux_rr_scheduler.sv
// Round-robin scheduler sharing one 1-bit stream among eight demux destinations.
// Each grant is a fixed BURST_LEN-beat burst; priority rotates past the last owner.
module demux_rr_scheduler #(
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned CNT_W     = 8
) (
  input  logic       clk,
  input  logic       reset,
  demux_rr_if.slave  bus
);

  localparam logic [0:0]       ST_IDLE   = 1'b0;
  localparam logic [0:0]       ST_XFER   = 1'b1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  logic [0:0]       state_q, state_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [2:0]       sel_q, sel_d;
  logic [7:0]       grant_q, grant_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             abort_q, abort_d;

  logic [15:0] req_dbl;
  logic [7:0]  req_rot;
  logic [2:0]  win_off;
  logic        win_found;
  logic [2:0]  win_idx;
  logic        ready;
  logic        beat;
  logic        last_beat;

  // Rotating the request vector by ptr turns the wrap-around search into a plain
  // lowest-set-bit search; win_off is then the distance from ptr.
  assign req_dbl = {bus.dst_req, bus.dst_req};
  assign req_rot = req_dbl[ptr_q +: 8];

  always_comb begin
    win_found = 1'b0;
    win_off   = 3'd0;
    for (int j = 7; j >= 0; j--) begin
      if (req_rot[j]) begin
        win_found = 1'b1;
        win_off   = 3'(j);
      end
    end
  end

  assign win_idx = ptr_q + win_off;

  assign ready     = (state_q == ST_XFER) && bus.dst_req[sel_q];
  assign beat      = ready && bus.in_valid;
  assign last_beat = beat && (cnt_q == LAST_BEAT);

  always_comb begin
    // NOTE: every next-state signal gets a default hold value first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    abort_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d = ST_XFER;
          sel_d   = win_idx;
          grant_d = 8'b0000_0001 << win_idx;
          cnt_d   = '0;
        end
      end

      ST_XFER: begin
        if (!ready) begin
          // Owner withdrew its request; in_ready is already low so no beat is lost.
          state_d = ST_IDLE;
          grant_d = 8'h00;
          ptr_d   = sel_q + 3'd1;
          cnt_d   = '0;
          abort_d = 1'b1;
        end else if (last_beat) begin
          state_d = ST_IDLE;
          grant_d = 8'h00;
          ptr_d   = sel_q + 3'd1;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else if (beat) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        grant_d = 8'h00;
        cnt_d   = '0;
      end
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= 3'd0;
      sel_q   <= 3'd0;
      grant_q <= 8'h00;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      abort_q <= abort_d;
    end
  end

  assign bus.in_ready    = ready;
  assign bus.demux_i     = bus.in_data & bus.in_valid & ready;
  assign bus.sel         = sel_q;
  assign bus.grant       = grant_q;
  assign bus.burst_done  = done_q;
  assign bus.burst_abort = abort_q;

endmodule

// File: tb/tb_demux_rr_scheduler.sv
// Self-checking bench: an owner/beat-count reference model is compared every cycle,
// plus directed phases that pin grant order, burst lengths, abort and reset behaviour.
module tb_demux_rr_scheduler;

  localparam int BURST_LEN = 4;

  logic clk;
  logic reset;
  demux_rr_if bus ();

  demux_rr_scheduler #(.BURST_LEN(BURST_LEN), .CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int mode    = 3;  // 0: valid always, 1: valid toggles in bursts, 2: random, 3: valid low

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model: who owns the stream and how many beats it has had
  int   m_owner;   // -1 when nobody holds a grant
  int   m_beats;
  int   m_ptr;
  int   m_sel;
  logic m_done;
  logic m_abort;

  function automatic int pick(input logic [7:0] req, input int p);
    for (int i = 0; i < 8; i++)
      if (req[(p + i) % 8]) return (p + i) % 8;
    return -1;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_owner <= -1;
      m_beats <= 0;
      m_ptr   <= 0;
      m_sel   <= 0;
      m_done  <= 1'b0;
      m_abort <= 1'b0;
    end else begin
      m_done  <= 1'b0;
      m_abort <= 1'b0;
      if (m_owner < 0) begin
        if (bus.dst_req != 8'h00) begin
          m_owner <= pick(bus.dst_req, m_ptr);
          m_sel   <= pick(bus.dst_req, m_ptr);
          m_beats <= 0;
        end
      end else if (!bus.dst_req[m_owner]) begin
        m_owner <= -1;
        m_ptr   <= (m_owner + 1) % 8;
        m_abort <= 1'b1;
      end else if (bus.in_valid) begin
        if (m_beats + 1 == BURST_LEN) begin
          m_owner <= -1;
          m_ptr   <= (m_owner + 1) % 8;
          m_done  <= 1'b1;
        end else begin
          m_beats <= m_beats + 1;
        end
      end
    end
  end

  function automatic logic [7:0] exp_grant(input int owner);
    return (owner < 0) ? 8'h00 : (8'h01 << owner);
  endfunction

  function automatic logic exp_ready(input int owner, input logic [7:0] req);
    return (owner < 0) ? 1'b0 : req[owner];
  endfunction

  always @(negedge clk) begin
    check("grant",       bus.grant,       exp_grant(m_owner));
    check("sel",         bus.sel,         m_sel);
    check("in_ready",    bus.in_ready,    exp_ready(m_owner, bus.dst_req));
    check("demux_i",     bus.demux_i,     bus.in_data & bus.in_valid & exp_ready(m_owner, bus.dst_req));
    check("burst_done",  bus.burst_done,  m_done);
    check("burst_abort", bus.burst_abort, m_abort);
  end

  // ---------------- monitor: grant history with start/end cycle, pulse counts
  logic [7:0] gq[$];
  int         gstart[$];
  int         gend[$];
  logic [7:0] last_g = 8'h00;
  int         cyc    = 0;
  int         n_done = 0;
  int         n_abort = 0;

  always @(negedge clk) begin
    if (bus.grant != 8'h00 && last_g == 8'h00) begin
      gq.push_back(bus.grant);
      gstart.push_back(cyc);
    end
    if (bus.grant == 8'h00 && last_g != 8'h00) gend.push_back(cyc);
    last_g  <= bus.grant;
    cyc     <= cyc + 1;
    n_done  <= n_done + int'(bus.burst_done);
    n_abort <= n_abort + int'(bus.burst_abort);
  end

  // ---------------- input driver, updates just after each rising edge
  initial begin
    bit ph;
    ph = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        0: begin
          bus.in_valid = 1'b1;
          bus.in_data  = 1'($urandom);
        end
        1: begin
          if (bus.grant == 8'h00) begin
            bus.in_valid = 1'b0;
            ph = 1'b0;
          end else begin
            bus.in_valid = ph;
            ph = ~ph;
          end
          bus.in_data = 1'($urandom);
        end
        2: begin
          if ($urandom_range(7) == 0) bus.dst_req = 8'($urandom);
          bus.in_valid = 1'($urandom);
          bus.in_data  = 1'($urandom);
        end
        default: begin
          bus.in_valid = 1'b0;
          bus.in_data  = 1'b0;
        end
      endcase
    end
  end

  int done_base;
  int abort_base;

  task automatic do_reset(input logic [7:0] req);
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.dst_req = req;
    repeat (2) @(posedge clk);
    #1;
    gq.delete();
    gstart.delete();
    gend.delete();
    done_base  = n_done;
    abort_base = n_abort;
    reset = 1'b1;
  endtask

  task automatic wait_grants(input int n, input int budget, input string nm);
    int c;
    c = 0;
    while (gq.size() < n && c < budget) begin
      @(negedge clk);
      #1;
      c++;
    end
    check(nm, 32'(gq.size() >= n), 32'd1);
  endtask

  task automatic wait_grant_val(input logic [7:0] v, input int budget, input string nm);
    int c;
    c = 0;
    while (bus.grant != v && c < budget) begin
      @(negedge clk);
      #1;
      c++;
    end
    check(nm, bus.grant, v);
  endtask

  initial begin
    reset        = 1'b0;
    bus.dst_req  = 8'hFF;
    bus.in_valid = 1'b0;
    bus.in_data  = 1'b0;
    done_base    = 0;
    abort_base   = 0;

    // Reset held with every requester asking
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_grant",    bus.grant,       8'h00);
    check("rst_sel",      bus.sel,         3'd0);
    check("rst_done",     bus.burst_done,  1'b0);
    check("rst_abort",    bus.burst_abort, 1'b0);
    check("rst_in_ready", bus.in_ready,    1'b0);
    check("rst_demux_i",  bus.demux_i,     1'b0);

    // Full rotation with continuous beats
    @(posedge clk);
    #1;
    mode  = 0;
    reset = 1'b1;
    wait_grants(9, 300, "rot_timeout");
    for (int i = 0; i < 9; i++)
      if (i < gq.size()) check("rot_grant", gq[i], 8'h01 << (i % 8));
    for (int i = 0; i < 8; i++)
      if (i < gend.size()) check("rot_len", gend[i] - gstart[i], BURST_LEN);
    if (gstart.size() > 1 && gend.size() > 0) check("rot_idle_gap", gstart[1] - gend[0], 1);
    check("rot_done_count", n_done - done_base, 8);

    // Sparse requests wrap from bit 7 back to bit 2
    do_reset(8'b1000_0100);
    wait_grants(3, 100, "sparse_timeout");
    if (gq.size() >= 3) begin
      check("sparse_g0", gq[0], 8'h04);
      check("sparse_g1", gq[1], 8'h80);
      check("sparse_g2", gq[2], 8'h04);
    end

    // Abort: requester 3 drops after two beats
    do_reset(8'h08);
    wait_grant_val(8'h08, 20, "abort_grant");
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    bus.dst_req = 8'h13;
    #1;
    check("abort_ready_fall", bus.in_ready, 1'b0);
    check("abort_demux_zero", bus.demux_i,  1'b0);
    @(negedge clk);
    #1;
    check("abort_not_yet", bus.burst_abort, 1'b0);
    @(negedge clk);
    #1;
    check("abort_pulse",       bus.burst_abort, 1'b1);
    check("abort_grant_clear", bus.grant,       8'h00);
    wait_grants(2, 20, "abort_next_timeout");
    if (gq.size() >= 2) check("abort_next_grant", gq[1], 8'h10);
    if (gend.size() >= 1) check("abort_len", gend[0] - gstart[0], 3);
    check("abort_count", n_abort - abort_base, 1);
    check("abort_no_done", n_done - done_base, 0);

    // Stall: in_valid alternates inside each burst
    mode = 1;
    do_reset(8'hFF);
    wait_grants(3, 100, "stall_timeout");
    if (gend.size() >= 2) begin
      check("stall_len0", gend[0] - gstart[0], 8);
      check("stall_len1", gend[1] - gstart[1], 8);
    end
    check("stall_done_count", n_done - done_base, 2);

    // Asynchronous reset in the middle of a burst
    mode = 0;
    do_reset(8'hFF);
    wait_grant_val(8'h04, 50, "midrst_grant");
    @(posedge clk);
    #1;
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_grant_clear", bus.grant,       8'h00);
    check("midrst_sel",         bus.sel,         3'd0);
    check("midrst_ready",       bus.in_ready,    1'b0);
    check("midrst_demux",       bus.demux_i,     1'b0);
    check("midrst_done",        bus.burst_done,  1'b0);
    check("midrst_abort",       bus.burst_abort, 1'b0);
    @(posedge clk);
    #1;
    bus.dst_req = 8'h30;
    @(posedge clk);
    #1;
    gq.delete();
    gstart.delete();
    gend.delete();
    reset = 1'b1;
    wait_grants(1, 20, "midrst_next_timeout");
    if (gq.size() >= 1) check("midrst_first_grant", gq[0], 8'h10);

    // Random traffic, checked by the model every cycle
    mode = 2;
    do_reset(8'($urandom));
    repeat (3000) @(posedge clk);

    mode = 3;
    repeat (4) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
